reg_file_seq: RTL and testbench

Bulk-access initiator for the 8x8 register file: accepts a command to either load a run of registers from an input byte stream or dump a run of registers onto an output stream. It drives the register file's write port (WRITEREG/WRITEDATA/WRITEENABLE) and read port 1 (READREG1/REGOUT1), acting as the master side of that interface. It is used for debug preload and state dump, and sits beside the CPU datapath behind an external arbitration mux.

---
 rtl/reg_file_seq_pkg.sv | 19 +
 rtl/reg_file_seq.sv | 116 +++++++++++
 tb/tb_reg_file_seq.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_seq_pkg.sv
// Shared definitions for the register-file bulk-access sequencer:
// state encodings, command opcodes and the default data/address widths.
package reg_file_seq_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   localparam logic OP_LOAD = 1'b0;
   localparam logic OP_DUMP = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_DUMP_RD  = 3'd2,
      ST_DUMP_OUT = 3'd3,
      ST_FINISH   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/reg_file_seq.sv
// Bulk load/dump sequencer mastering the register file's write port and read port 1.
// Loads a run of registers from an input byte stream or dumps a run onto an output stream.
module reg_file_seq
   import reg_file_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_start,
   input  logic [ADDR_W-1:0] cmd_count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W-1:0] writereg,
   output logic [DATA_W-1:0] writedata,
   output logic              writeenable,
   output logic [ADDR_W-1:0] readreg1,
   input  logic [DATA_W-1:0] regout1,
   output logic              done,
   output logic [2:0]        state_dbg
);

   // Remaining count needs one extra bit so that a count field of 0 can mean 2^ADDR_W.
   localparam int CNT_W = ADDR_W + 1;

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              out_valid_q, out_valid_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Every stream and command port transfers on a rising edge where valid and ready
   // are both high; a valid, once raised, is held with its payload until that edge.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_start;
               rem_d   = (cmd_count == '0) ? CNT_W'(1 << ADDR_W) : CNT_W'(cmd_count);
               state_d = (cmd_op == OP_DUMP) ? ST_DUMP_RD : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) state_d = ST_FINISH;
            end
         end
         ST_DUMP_RD: begin
            out_data_d  = regout1;
            out_addr_d  = addr_q;
            out_valid_d = 1'b1;
            state_d     = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               addr_d      = addr_q + 1'b1;
               rem_d       = rem_q - 1'b1;
               state_d     = (rem_q == CNT_W'(1)) ? ST_FINISH : ST_DUMP_RD;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign in_ready    = (state_q == ST_LOAD);
   assign writeenable = in_ready & in_valid;
   assign writereg    = addr_q;
   // Write data is a passthrough of the stream, forced to zero outside LOAD.
   assign writedata   = in_ready ? in_data : '0;
   assign readreg1    = addr_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_addr    = out_addr_q;
   assign done        = (state_q == ST_FINISH);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_reg_file_seq.sv
// Randomized self-checking bench for reg_file_seq, driving a behavioural 8x8 register
// file and comparing against an array model of the registers plus an expected dump queue.
module tb_reg_file_seq;
  import reg_file_seq_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [2:0] cmd_start, cmd_count;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [2:0] out_addr;
  logic [2:0] writereg;
  logic [7:0] writedata;
  logic       writeenable;
  logic [2:0] readreg1;
  logic [7:0] regout1;
  logic       done;
  logic [2:0] state_dbg;

  // register file attached to the sequencer
  logic [7:0] rf [8];
  always @(posedge clk) if (writeenable) rf[writereg] <= writedata;
  assign regout1 = rf[readreg1];

  // reference model and scoreboard
  logic [7:0]  model [8];
  logic [10:0] exp_q [$];
  logic [7:0]  data_q [$];
  bit          pat_q [$];
  int          checks = 0;
  int          errors = 0;

  reg_file_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_start(cmd_start), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .writereg(writereg), .writedata(writedata), .writeenable(writeenable),
    .readreg1(readreg1), .regout1(regout1), .done(done), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_regs(input string tag);
    for (int k = 0; k < 8; k++) check($sformatf("%s_r%0d", tag, k), rf[k], model[k]);
  endtask

  // Issues a LOAD from IDLE; beats come from data_q, in_valid per cycle from pat_q, then random.
  task automatic do_load(input logic [2:0] start, input logic [2:0] count);
    int n, i, cyc, p;
    bit v;
    logic [2:0] a;
    n = (count == 0) ? 8 : count;
    i = 0; cyc = 0; p = 0;
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_start = start; cmd_count = count;
    #1;
    check("load_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    while (i < n && cyc < 200) begin
      v = (p < pat_q.size()) ? pat_q[p] : 1'($urandom_range(0, 1));
      p++;
      in_valid = v;
      in_data  = v ? data_q[i] : 8'($urandom);
      #1;
      check("load_in_ready", in_ready, 1);
      check("load_we", writeenable, v);
      check("load_done_early", done, 0);
      if (v) begin
        a = start + 3'(i);
        check("load_wreg", writereg, a);
        check("load_wdata", writedata, data_q[i]);
        model[a] = data_q[i];
        i++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (i < n) check("load_timeout", i, n);
    #1;
    check("load_done", done, 1);
    check("load_we_finish", writeenable, 0);
    check("load_in_ready_finish", in_ready, 0);
    tick();
    #1;
    check("load_done_fall", done, 0);
    check("load_idle_ready", cmd_ready, 1);
  endtask

  // Issues a DUMP; with hold set, a LOAD command (hstart/hcount) stays offered throughout.
  task automatic do_dump(input logic [2:0] start, input logic [2:0] count, input bit hold,
                         input logic [2:0] hstart, input logic [2:0] hcount);
    int n, beats, cyc;
    bit stalled;
    logic [7:0] pd;
    logic [2:0] pa, a;
    logic [10:0] e;
    n = (count == 0) ? 8 : count;
    for (int i = 0; i < n; i++) begin
      a = start + 3'(i);
      exp_q.push_back({a, model[a]});
    end
    beats = 0; cyc = 0; stalled = 0; pd = '0; pa = '0;
    cmd_valid = 1'b1; cmd_op = OP_DUMP; cmd_start = start; cmd_count = count;
    #1;
    check("dump_cmd_ready", cmd_ready, 1);
    tick();
    if (hold) begin
      cmd_op = OP_LOAD; cmd_start = hstart; cmd_count = hcount;
    end else begin
      cmd_valid = 1'b0;
    end
    while (beats < n && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) check("dump_first_valid_low", out_valid, 0);
      if (cyc == 1) check("dump_first_valid_high", out_valid, 1);
      check("dump_we", writeenable, 0);
      check("dump_cmd_blocked", cmd_ready, 0);
      if (out_valid) begin
        if (stalled) begin
          check("dump_hold_data", out_data, pd);
          check("dump_hold_addr", out_addr, pa);
        end
        if (out_ready) begin
          e = exp_q.pop_front();
          check("dump_addr", out_addr, e[10:8]);
          check("dump_data", out_data, e[7:0]);
          beats++;
          stalled = 0;
        end else begin
          stalled = 1; pd = out_data; pa = out_addr;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (beats < n) begin
      check("dump_timeout", beats, n);
      exp_q.delete();
    end
    #1;
    check("dump_done", done, 1);
    check("dump_finish_ready", cmd_ready, 0);
    check("dump_valid_finish", out_valid, 0);
    tick();
    #1;
    check("dump_done_fall", done, 0);
    check("dump_idle_ready", cmd_ready, 1);
  endtask

  initial begin
    logic [7:0] d0, d1;
    reset_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_start = 0; cmd_count = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_we", writeenable, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_wreg", writereg, 0);
    check("rst_wdata", writedata, 0);
    check("rst_rreg", readreg1, 0);
    reset_n = 1'b1;
    repeat (2) begin
      tick();
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_we", writeenable, 0);
    end

    // define every register
    data_q.delete(); pat_q.delete();
    for (int k = 0; k < 8; k++) data_q.push_back(8'($urandom));
    pat_q = {1, 1, 1, 1, 1, 1, 1, 1};
    do_load(3'd0, 3'd0);
    compare_regs("init");

    // back-to-back load of three
    data_q = {8'd95, 8'd28, 8'd6};
    pat_q = {1, 1, 1};
    do_load(3'd2, 3'd3);
    compare_regs("load_b2b");

    // wrapping load with in_valid gaps
    data_q = {8'd10, 8'd20, 8'd30, 8'd40};
    pat_q = {1, 0, 1, 1, 0, 1};
    do_load(3'd6, 3'd4);
    compare_regs("load_gap");

    // preload Rk = k*3, then dump all eight
    data_q.delete();
    for (int k = 0; k < 8; k++) data_q.push_back(8'(k * 3));
    pat_q.delete();
    do_load(3'd0, 3'd0);
    compare_regs("preload");
    do_dump(3'd0, 3'd0, 0, 3'd0, 3'd0);

    // reset during the second beat of a count-5 load
    d0 = 8'($urandom); d1 = 8'($urandom);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_start = 3'd3; cmd_count = 3'd5;
    tick();
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_data = d0;
    #1;
    check("abort_we_beat1", writeenable, 1);
    model[3] = d0;
    tick();
    in_valid = 1'b1; in_data = d1;
    #1;
    check("abort_we_beat2", writeenable, 1);
    reset_n = 1'b0;
    #1;
    check("abort_we_drop", writeenable, 0);
    check("abort_done", done, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    reset_n = 1'b1;
    repeat (2) begin
      tick();
      check("abort_no_done", done, 0);
    end
    compare_regs("abort");
    data_q = {8'($urandom)};
    pat_q.delete();
    do_load(3'd7, 3'd1);
    compare_regs("after_abort");

    // command held during a dump is taken when IDLE returns
    do_dump(3'd5, 3'd3, 1, 3'd1, 3'd2);
    data_q = {8'($urandom), 8'($urandom)};
    pat_q.delete();
    do_load(3'd1, 3'd2);
    compare_regs("held_cmd");

    // random mix
    repeat (8) begin
      logic [2:0] s, c;
      s = 3'($urandom_range(0, 7));
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        data_q.delete(); pat_q.delete();
        for (int k = 0; k < 8; k++) data_q.push_back(8'($urandom));
        do_load(s, c);
      end else begin
        do_dump(s, c, 0, 3'd0, 3'd0);
      end
    end
    compare_regs("random");
    do_dump(3'd0, 3'd0, 0, 3'd0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
